// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the IF/ID/EX front end.
// Produces freeze/flush/bubble controls from registered state plus same-cycle pipeline inputs:
// data hazards (load-use, or any RAW without forwarding), taken-branch flush sequences and
// whole-pipe freezes while data memory is busy.
module hazard_stall_ctrl #(
  parameter int unsigned REG_W     = 4,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned MAX_WAIT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_r_en,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_if,
  output logic             flush_if,
  output logic             bubble_id,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [31:0]      stall_cycles
);

  localparam int unsigned WaitW  = $clog2(MAX_WAIT + 1);
  localparam int unsigned FlushW = $clog2(FLUSH_CYC + 1);

  localparam logic [WaitW-1:0]  MaxWait     = WaitW'(MAX_WAIT);
  localparam logic [FlushW-1:0] FlushReload = FlushW'(FLUSH_CYC - 1);
  // A single-cycle flush is fully handled in the branch cycle itself.
  localparam bit                FlushMulti  = (FLUSH_CYC > 1);

  typedef enum logic [1:0] {StRun, StMemWait, StFlush} state_e;

  state_e            state_q, state_d;
  logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       stall_q, stall_d;

  logic hz_exe, hz_mem, data_hz, mem_stall, count_wait;
  logic freeze_if_raw, flush_if_raw, bubble_id_raw, freeze_all_raw;

  // RAW hazard detection against the EXE and MEM stage destinations.
  always_comb begin
    hz_exe    = exe_wb_en & ((src1 == exe_dest) | (two_src & (src2 == exe_dest)));
    hz_mem    = mem_wb_en & ((src1 == mem_dest) | (two_src & (src2 == mem_dest)));
    data_hz   = forward_en ? (hz_exe & exe_mem_r_en) : (hz_exe | hz_mem);
    mem_stall = mem_req & ~mem_ready;
  end

  // Next-state and raw control decode; priority in RUN is memory stall > branch > data hazard.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
    count_wait     = 1'b0;
    freeze_if_raw  = 1'b0;
    flush_if_raw   = 1'b0;
    bubble_id_raw  = 1'b0;
    freeze_all_raw = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          freeze_all_raw = 1'b1;
          freeze_if_raw  = 1'b1;
          wait_cnt_d     = WaitW'(1);
          count_wait     = 1'b1;
          state_d        = StMemWait;
        end else if (branch_taken) begin
          flush_if_raw  = 1'b1;
          bubble_id_raw = 1'b1;
          if (FlushMulti) begin
            flush_cnt_d = FlushReload;
            state_d     = StFlush;
          end
        end else if (data_hz) begin
          freeze_if_raw = 1'b1;
          bubble_id_raw = 1'b1;
        end
      end

      StMemWait: begin
        if (mem_ready) begin
          wait_cnt_d = '0;
          state_d    = StRun;
        end else begin
          freeze_all_raw = 1'b1;
          freeze_if_raw  = 1'b1;
          count_wait     = 1'b1;
          if (wait_cnt_q < MaxWait) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end

      StFlush: begin
        flush_if_raw = 1'b1;
        if (mem_stall) begin
          // Pipe is frozen, so the flush sequence simply pauses.
          freeze_all_raw = 1'b1;
        end else if (branch_taken) begin
          flush_cnt_d = FlushReload;
          if (!FlushMulti) begin
            state_d = StRun;
          end
        end else if (flush_cnt_q <= FlushW'(1)) begin
          flush_cnt_d = '0;
          state_d     = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase

    if (count_wait && (wait_cnt_d == MaxWait)) begin
      timeout_d = 1'b1;
    end
  end

  // Controls are forced low while reset is asserted.
  always_comb begin
    freeze_if  = rst & freeze_if_raw;
    flush_if   = rst & flush_if_raw;
    bubble_id  = rst & bubble_id_raw;
    freeze_all = rst & freeze_all_raw;
    stall_d    = (freeze_if && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios followed by random traffic, all checked
// cycle by cycle against a behavioural model of the stall/flush rules.
module tb_hazard_stall_ctrl;

  localparam int unsigned REG_W     = 4;
  localparam int unsigned FLUSH_CYC = 2;
  localparam int unsigned MAX_WAIT  = 4;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] src1, src2, exe_dest, mem_dest;
  logic             two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, forward_en;
  logic             branch_taken, mem_req, mem_ready;
  logic             freeze_if, flush_if, bubble_id, freeze_all, mem_timeout;
  logic [31:0]      stall_cycles;

  hazard_stall_ctrl #(
    .REG_W    (REG_W),
    .FLUSH_CYC(FLUSH_CYC),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src1        (src1),
    .src2        (src2),
    .two_src     (two_src),
    .exe_wb_en   (exe_wb_en),
    .exe_dest    (exe_dest),
    .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en   (mem_wb_en),
    .mem_dest    (mem_dest),
    .forward_en  (forward_en),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .freeze_if   (freeze_if),
    .flush_if    (flush_if),
    .bubble_id   (bubble_id),
    .freeze_all  (freeze_all),
    .mem_timeout (mem_timeout),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: remaining flush cycles after the current one, memory-wait flag and length,
  // sticky timeout and saturating stall count.
  int          m_flush_left = 0;
  bit          m_waiting    = 0;
  int          m_wait_len   = 0;
  bit          m_to         = 0;
  int unsigned m_stall      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit reads_reg(input logic [REG_W-1:0] d);
    return (src1 == d) || (two_src && (src2 == d));
  endfunction

  function automatic bit model_data_hz();
    bit e, m;
    e = exe_wb_en && reads_reg(exe_dest);
    m = mem_wb_en && reads_reg(mem_dest);
    if (forward_en) return e && exe_mem_r_en;
    return e || m;
  endfunction

  // Check one cycle against the model, then advance model and clock together.
  task automatic cycle();
    bit e_fi, e_fl, e_bub, e_fa, stall_req, hz;
    e_fi = 0; e_fl = 0; e_bub = 0; e_fa = 0;
    stall_req = mem_req && !mem_ready;
    hz        = model_data_hz();
    if (rst) begin
      if (m_waiting) begin
        e_fa = !mem_ready;
        e_fi = !mem_ready;
      end else if (m_flush_left > 0) begin
        e_fl = 1;
        e_fa = stall_req;
      end else if (stall_req) begin
        e_fa = 1;
        e_fi = 1;
      end else if (branch_taken) begin
        e_fl  = 1;
        e_bub = 1;
      end else if (hz) begin
        e_fi  = 1;
        e_bub = 1;
      end
    end
    #2;
    check("freeze_if", {31'd0, freeze_if}, {31'd0, e_fi});
    check("flush_if", {31'd0, flush_if}, {31'd0, e_fl});
    check("bubble_id", {31'd0, bubble_id}, {31'd0, e_bub});
    check("freeze_all", {31'd0, freeze_all}, {31'd0, e_fa});
    check("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
    check("stall_cycles", stall_cycles, m_stall);
    if (!rst) begin
      m_flush_left = 0; m_waiting = 0; m_wait_len = 0; m_to = 0; m_stall = 0;
    end else begin
      if (e_fi && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (m_waiting) begin
        if (mem_ready) m_waiting = 0;
        else begin
          if (m_wait_len < MAX_WAIT) m_wait_len++;
          if (m_wait_len == MAX_WAIT) m_to = 1;
        end
      end else if (m_flush_left > 0) begin
        if (!stall_req) begin
          if (branch_taken) m_flush_left = FLUSH_CYC - 1;
          else m_flush_left--;
        end
      end else if (stall_req) begin
        m_waiting  = 1;
        m_wait_len = 1;
        if (MAX_WAIT == 1) m_to = 1;
      end else if (branch_taken) begin
        m_flush_left = FLUSH_CYC - 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    src1 = '0; src2 = '0; exe_dest = 4'd15; mem_dest = 4'd15;
    two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0; forward_en = 1;
    branch_taken = 0; mem_req = 0; mem_ready = 1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    // Reset state, with hazard-looking inputs that must stay masked.
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1; branch_taken = 1;
    cycle();
    rst = 1;
    idle_inputs();
    cycle();

    // Load-use with forwarding: one stall cycle.
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3; src1 = 4'd3; forward_en = 1;
    cycle();
    idle_inputs();
    cycle();
    check("t1_stall_count", stall_cycles, 32'd1);

    // Forwarding off: MEM-stage RAW via src2, then not read.
    forward_en = 0; mem_wb_en = 1; mem_dest = 4'd5; two_src = 1; src2 = 4'd5; src1 = 4'd0;
    cycle();
    two_src = 0;
    cycle();
    idle_inputs();

    // Taken branch: two flush cycles, bubble on the first only.
    branch_taken = 1;
    cycle();
    branch_taken = 0;
    cycle();
    cycle();

    // Memory wait of three cycles, then ready.
    mem_req = 1; mem_ready = 0;
    repeat (3) cycle();
    mem_ready = 1;
    cycle();
    mem_req = 0;
    cycle();

    // Timeout: six waiting cycles with MAX_WAIT = 4.
    mem_req = 1; mem_ready = 0;
    repeat (6) cycle();
    mem_ready = 1;
    cycle();
    idle_inputs();
    cycle();
    check("t5_timeout_sticky", {31'd0, mem_timeout}, 32'd1);

    // Priority: stall + branch + data hazard in one cycle, then reset mid-wait.
    mem_req = 1; mem_ready = 0; branch_taken = 1;
    exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 4'd3; src1 = 4'd3;
    cycle();
    cycle();
    rst = 0;
    cycle();
    rst = 1;
    idle_inputs();
    cycle();
    check("t6_stall_cleared", stall_cycles, 32'd0);
    check("t6_timeout_cleared", {31'd0, mem_timeout}, 32'd0);

    // Random traffic: small register space so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) >= 2);
      src1         = REG_W'($urandom_range(0, 3));
      src2         = REG_W'($urandom_range(0, 3));
      exe_dest     = REG_W'($urandom_range(0, 3));
      mem_dest     = REG_W'($urandom_range(0, 3));
      two_src      = $urandom_range(0, 1) == 1;
      exe_wb_en    = $urandom_range(0, 1) == 1;
      exe_mem_r_en = $urandom_range(0, 1) == 1;
      mem_wb_en    = $urandom_range(0, 1) == 1;
      forward_en   = $urandom_range(0, 1) == 1;
      branch_taken = $urandom_range(0, 99) < 15;
      mem_req      = $urandom_range(0, 1) == 1;
      mem_ready    = $urandom_range(0, 99) < 65;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
